// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request/response port between NumPorts requesters.
// An in-order tag FIFO remembers which requester owns each in-flight request so responses are steered back.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int NumPorts       = 4,
  parameter int ReqWidth       = 64,
  parameter int RespWidth      = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumPorts*ReqWidth-1:0]         req_i,
  input  logic [NumPorts-1:0]                  req_valid_i,
  output logic [NumPorts-1:0]                  req_ready_o,
  output logic [NumPorts*RespWidth-1:0]        resp_o,
  output logic [NumPorts-1:0]                  resp_valid_o,
  input  logic [NumPorts-1:0]                  resp_ready_i,
  output logic [ReqWidth-1:0]                  mem_req_o,
  output logic                                 mem_req_valid_o,
  input  logic                                 mem_req_ready_i,
  input  logic [RespWidth-1:0]                 mem_resp_i,
  input  logic                                 mem_resp_valid_i,
  output logic                                 mem_resp_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);

  localparam int IdxW = $clog2(NumPorts);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdxW-1:0] r_rr;
  logic            r_lock;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_tag [MaxOutstanding];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic            w_any;
  logic [IdxW-1:0] w_gnt;
  logic [IdxW-1:0] w_cand;
  logic [IdxW-1:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IdxW-1:0] port_inc(input logic [IdxW-1:0] p);
    return (p == IdxW'(NumPorts - 1)) ? '0 : p + 1'b1;
  endfunction

  // Scan downward so the lowest offset from r_rr is written last and wins.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_cand = '0;
    if (r_lock) begin
      w_any = 1'b1;
      w_gnt = r_lock_idx;
    end else begin
      for (int i = NumPorts - 1; i >= 0; i--) begin
        w_cand = IdxW'((int'(r_rr) + i) % NumPorts);
        if (req_valid_i[w_cand]) begin
          w_any = 1'b1;
          w_gnt = w_cand;
        end
      end
    end
  end

  assign w_full  = (r_count == CntW'(MaxOutstanding));
  assign w_empty = (r_count == '0);
  assign w_head  = r_tag[r_rptr];

  // Outputs are forced low while reset is asserted, independent of the live request inputs.
  assign mem_req_valid_o  = !rst_i && w_any && !w_full;
  assign mem_req_o        = req_i[w_gnt*ReqWidth +: ReqWidth];
  assign mem_resp_ready_o = !rst_i && !w_empty && resp_ready_i[w_head];
  assign resp_o           = {NumPorts{mem_resp_i}};
  assign outstanding_o    = r_count;

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    if (!rst_i && w_any) req_ready_o[w_gnt] = mem_req_ready_i && !w_full;
    if (!rst_i && !w_empty) resp_valid_o[w_head] = mem_resp_valid_i;
  end

  assign w_push = mem_req_valid_o && mem_req_ready_i;
  assign w_pop  = mem_resp_valid_i && mem_resp_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
        r_rr   <= port_inc(w_gnt);
        r_lock <= 1'b0;
      end else if (mem_req_valid_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_gnt;
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag storage carries no reset; stale entries are never read because count gates the head.
  always_ff @(posedge clk_i) begin
    if (w_push) r_tag[r_wptr] <= w_gnt;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected requests/responses,
// a negedge monitor pops and compares on every downstream request or response handshake.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int NP = 4;
  localparam int RW = 64;
  localparam int SW = 32;
  localparam int MO = 4;

  logic              clk;
  logic              rst;
  logic [NP*RW-1:0]  req_i;
  logic [NP-1:0]     req_valid_i;
  logic [NP-1:0]     req_ready_o;
  logic [NP*SW-1:0]  resp_o;
  logic [NP-1:0]     resp_valid_o;
  logic [NP-1:0]     resp_ready_i;
  logic [RW-1:0]     mem_req_o;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [SW-1:0]     mem_resp_i;
  logic              mem_resp_valid_i;
  logic              mem_resp_ready_o;
  logic [2:0]        outstanding_o;

  typedef struct {int port; logic [RW-1:0] data;} req_t;
  typedef struct {int port; logic [SW-1:0] data;} resp_t;
  req_t  exp_req[$];
  resp_t exp_resp[$];

  int checks   = 0;
  int failures = 0;

  localparam logic [SW-1:0] DBASE = 32'hD000_0000;

  mem_port_arbiter #(.NumPorts(NP), .ReqWidth(RW), .RespWidth(SW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_o(resp_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .mem_req_o(mem_req_o), .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
    .outstanding_o(outstanding_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] pay(input int k);
    return 64'h1111_1111_1111_1111 * (k + 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int p);
    req_t e;
    e.port = p;
    e.data = pay(p);
    exp_req.push_back(e);
  endtask

  task automatic push_resp(input int p, input logic [SW-1:0] d);
    resp_t e;
    e.port = p;
    e.data = d;
    exp_resp.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mem_req_valid_o && mem_req_ready_i) begin
      if (exp_req.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL req_unexpected actual=%0h expected=none at %0t", mem_req_o, $time);
      end else begin
        req_t e;
        e = exp_req.pop_front();
        chk("req_payload", mem_req_o, e.data);
        chk("req_ready_onehot", 64'(req_ready_o), 64'(1) << e.port);
      end
    end
    if (mem_resp_valid_i && mem_resp_ready_o) begin
      if (exp_resp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual=%0h expected=none at %0t", resp_valid_o, $time);
      end else begin
        resp_t e;
        e = exp_resp.pop_front();
        chk("resp_valid_onehot", 64'(resp_valid_o), 64'(1) << e.port);
        chk("resp_data", 64'(resp_o[e.port*SW +: SW]), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NP; k++) req_i[k*RW +: RW] = pay(k);
    rst = 1'b1;
    req_valid_i = 4'hF;
    mem_req_ready_i = 1'b1;
    mem_resp_valid_i = 1'b1;
    mem_resp_i = DBASE;
    resp_ready_i = 4'hF;
    #3;
    chk("reset_req_valid", 64'(mem_req_valid_o), 0);
    chk("reset_req_ready", 64'(req_ready_o), 0);
    chk("reset_resp_ready", 64'(mem_resp_ready_o), 0);
    chk("reset_resp_valid", 64'(resp_valid_o), 0);
    chk("reset_outstanding", 64'(outstanding_o), 0);
    req_valid_i = '0;
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Round-robin with a response one cycle behind every request
    for (int n = 0; n < 8; n++) push_req(n % NP);
    req_valid_i = 4'hF;
    mem_req_ready_i = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      if (n >= 1) begin
        mem_resp_valid_i = 1'b1;
        mem_resp_i = DBASE + SW'(n - 1);
        push_resp((n - 1) % NP, DBASE + SW'(n - 1));
      end
      if (n == 8) req_valid_i = '0;
      step();
    end
    mem_resp_valid_i = 1'b0;
    @(negedge clk);
    chk("rr_outstanding_drained", 64'(outstanding_o), 0);
    step();

    // Lock: port 2 stalls for 3 cycles while port 1 raises valid
    req_valid_i = 4'b0100;
    mem_req_ready_i = 1'b0;
    @(negedge clk);
    chk("lock_req_valid", 64'(mem_req_valid_o), 1);
    chk("lock_first_payload", mem_req_o, pay(2));
    step();
    req_valid_i = 4'b0110;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("lock_hold_payload", mem_req_o, pay(2));
      chk("lock_hold_ready", 64'(req_ready_o), 0);
      step();
    end
    mem_req_ready_i = 1'b1;
    push_req(2);
    step();
    req_valid_i = 4'b0010;
    push_req(1);
    step();
    req_valid_i = '0;
    mem_resp_valid_i = 1'b1;
    mem_resp_i = DBASE + 8;
    push_resp(2, DBASE + 8);
    step();
    mem_resp_i = DBASE + 9;
    push_resp(1, DBASE + 9);
    step();
    mem_resp_valid_i = 1'b0;

    // Full: four accepted, then a pop with a same-cycle request
    req_valid_i = 4'hF;
    push_req(2); push_req(3); push_req(0); push_req(1);
    repeat (4) step();
    @(negedge clk);
    chk("full_outstanding", 64'(outstanding_o), 4);
    chk("full_req_valid", 64'(mem_req_valid_o), 0);
    chk("full_req_ready", 64'(req_ready_o), 0);
    step();
    mem_resp_valid_i = 1'b1;
    mem_resp_i = DBASE + 10;
    push_resp(2, DBASE + 10);
    @(negedge clk);
    chk("full_pop_req_valid", 64'(mem_req_valid_o), 0);
    chk("full_pop_resp_ready", 64'(mem_resp_ready_o), 1);
    step();
    mem_resp_valid_i = 1'b0;
    push_req(2);
    @(negedge clk);
    chk("after_pop_outstanding", 64'(outstanding_o), 3);
    chk("after_pop_req_valid", 64'(mem_req_valid_o), 1);
    step();
    req_valid_i = '0;

    // Response backpressure on head tag 3
    mem_resp_valid_i = 1'b1;
    mem_resp_i = DBASE + 11;
    resp_ready_i = 4'b0111;
    @(negedge clk);
    chk("bp_resp_ready", 64'(mem_resp_ready_o), 0);
    chk("bp_resp_valid", 64'(resp_valid_o), 64'b1000);
    step();
    @(negedge clk);
    chk("bp_outstanding_held", 64'(outstanding_o), 4);
    step();
    resp_ready_i = 4'hF;
    push_resp(3, DBASE + 11);
    step();
    mem_resp_i = DBASE + 12;
    push_resp(0, DBASE + 12);
    @(negedge clk);
    chk("bp_pop_outstanding", 64'(outstanding_o), 3);
    step();
    mem_resp_i = DBASE + 13;
    push_resp(1, DBASE + 13);
    step();
    mem_resp_i = DBASE + 14;
    push_resp(2, DBASE + 14);
    step();

    // Empty: stray response is held off
    mem_resp_i = DBASE + 15;
    @(negedge clk);
    chk("empty_resp_ready", 64'(mem_resp_ready_o), 0);
    chk("empty_resp_valid", 64'(resp_valid_o), 0);
    chk("empty_outstanding", 64'(outstanding_o), 0);
    step();
    @(negedge clk);
    chk("empty_resp_ready_hold", 64'(mem_resp_ready_o), 0);
    step();
    mem_resp_valid_i = 1'b0;

    // Reset with two outstanding and a lock held on port 2
    req_valid_i = 4'b0011;
    push_req(0);
    push_req(1);
    repeat (2) step();
    req_valid_i = 4'b0100;
    mem_req_ready_i = 1'b0;
    step();
    rst = 1'b1;
    #1;
    req_valid_i = 4'hF;
    mem_req_ready_i = 1'b1;
    mem_resp_valid_i = 1'b1;
    #1;
    chk("midrst_req_valid", 64'(mem_req_valid_o), 0);
    chk("midrst_req_ready", 64'(req_ready_o), 0);
    chk("midrst_resp_ready", 64'(mem_resp_ready_o), 0);
    chk("midrst_resp_valid", 64'(resp_valid_o), 0);
    chk("midrst_outstanding", 64'(outstanding_o), 0);
    step();
    step();
    rst = 1'b0;
    mem_resp_valid_i = 1'b0;
    push_req(0);
    step();
    req_valid_i = '0;
    mem_resp_valid_i = 1'b1;
    mem_resp_i = DBASE + 16;
    push_resp(0, DBASE + 16);
    step();
    mem_resp_valid_i = 1'b0;
    step();
    @(negedge clk);
    chk("leftover_req", 64'(exp_req.size()), 0);
    chk("leftover_resp", 64'(exp_resp.size()), 0);
    chk("final_outstanding", 64'(outstanding_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
